// File: rtl/msf_pkg.sv
// Shared definitions for the MSF time-code encoder.
//   - second indices where each frame field starts
//   - slot counts for the carrier keying
//   - encoder FSM state and input snapshot types
//   - frame_bits(): A/B bit pair for a given second of a captured frame
package msf_pkg;

  localparam logic [5:0] SEC_LAST        = 6'd59;
  localparam logic [5:0] SEC_YEAR_FIRST  = 6'd17;
  localparam logic [5:0] SEC_MONTH_FIRST = 6'd25;
  localparam logic [5:0] SEC_DAY_FIRST   = 6'd30;
  localparam logic [5:0] SEC_DOW_FIRST   = 6'd36;
  localparam logic [5:0] SEC_HOUR_FIRST  = 6'd39;
  localparam logic [5:0] SEC_MIN_FIRST   = 6'd45;
  localparam logic [5:0] SEC_MIN_END     = 6'd52;
  localparam logic [5:0] SEC_PAR_YEAR    = 6'd53;
  localparam logic [5:0] SEC_PAR_MD      = 6'd54;
  localparam logic [5:0] SEC_PAR_DOW     = 6'd55;
  localparam logic [5:0] SEC_PAR_HM      = 6'd56;
  localparam logic [5:0] SEC_BST_WARN    = 6'd57;
  localparam logic [5:0] SEC_BST         = 6'd58;

  localparam logic [3:0] SLOTS_PER_SECOND = 4'd10;
  localparam logic [3:0] MARKER_SLOTS     = 4'd5;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  typedef struct packed {
    logic [7:0] year;
    logic [4:0] month;
    logic [5:0] day;
    logic [2:0] dow;
    logic [5:0] hour;
    logic [6:0] minute;
    logic       bst_warn;
    logic       bst;
  } snapshot_t;

  // Returns {A, B} for second 'sec'. Fields go out MSB first, so the bit
  // index is the distance from the field's last second.
  function automatic logic [1:0] frame_bits(input logic [5:0] sec, input snapshot_t s);
    logic a, b;
    a = 1'b0;
    b = 1'b0;
    if (sec == 6'd0) begin
      a = 1'b1;
      b = 1'b1;
    end else if (sec >= SEC_YEAR_FIRST && sec < SEC_MONTH_FIRST)
      a = s.year[3'(SEC_MONTH_FIRST - 6'd1 - sec)];
    else if (sec >= SEC_MONTH_FIRST && sec < SEC_DAY_FIRST)
      a = s.month[3'(SEC_DAY_FIRST - 6'd1 - sec)];
    else if (sec >= SEC_DAY_FIRST && sec < SEC_DOW_FIRST)
      a = s.day[3'(SEC_DOW_FIRST - 6'd1 - sec)];
    else if (sec >= SEC_DOW_FIRST && sec < SEC_HOUR_FIRST)
      a = s.dow[2'(SEC_HOUR_FIRST - 6'd1 - sec)];
    else if (sec >= SEC_HOUR_FIRST && sec < SEC_MIN_FIRST)
      a = s.hour[3'(SEC_MIN_FIRST - 6'd1 - sec)];
    else if (sec >= SEC_MIN_FIRST && sec < SEC_MIN_END)
      a = s.minute[3'(SEC_MIN_END - 6'd1 - sec)];
    else if (sec >= SEC_PAR_YEAR && sec <= SEC_BST)
      a = 1'b1;

    // Odd parity: parity bit makes the covered group's ones count odd.
    case (sec)
      SEC_PAR_YEAR: b = ~^s.year;
      SEC_PAR_MD:   b = ~^{s.month, s.day};
      SEC_PAR_DOW:  b = ~^s.dow;
      SEC_PAR_HM:   b = ~^{s.hour, s.minute};
      SEC_BST_WARN: b = s.bst_warn;
      SEC_BST:      b = s.bst;
      default:      ;
    endcase
    return {a, b};
  endfunction

endpackage

// File: rtl/msf_carrier_modulator.sv
// Carrier on/off keying for one MSF second.
//   clk, rst_n   : clock, async active-low reset
//   tick         : starts a new second (slot 0) on the next cycle
//   a, b         : A/B bits of the second being started (sampled with tick)
//   is_second_00 : second being started is the minute marker
//   carrier_off  : 1 = carrier off
module msf_carrier_modulator
  import msf_pkg::*;
#(
  parameter int SLOT_CYCLES = 3277
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic a,
  input  logic b,
  input  logic is_second_00,
  output logic carrier_off
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(SLOT_CYCLES - 1);

  logic          active;
  logic [3:0]    slot;
  logic [CW-1:0] cyc;
  logic          a_q, b_q, marker_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      slot     <= '0;
      cyc      <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      marker_q <= 1'b0;
    end else if (tick) begin
      // A tick always wins, aborting whatever second was in progress.
      active   <= 1'b1;
      slot     <= '0;
      cyc      <= '0;
      a_q      <= a;
      b_q      <= b;
      marker_q <= is_second_00;
    end else if (active) begin
      if (cyc == CYC_LAST) begin
        cyc <= '0;
        if (slot == SLOTS_PER_SECOND - 4'd1) active <= 1'b0;
        else                                 slot   <= slot + 4'd1;
      end else begin
        cyc <= cyc + CW'(1);
      end
    end
  end

  // Once the ten slots have run out the carrier stays on until the next tick.
  always_comb begin
    carrier_off = 1'b0;
    if (active) begin
      if (marker_q) carrier_off = (slot < MARKER_SLOTS);
      else begin
        case (slot)
          4'd0:    carrier_off = 1'b1;
          4'd1:    carrier_off = a_q;
          4'd2:    carrier_off = b_q;
          default: carrier_off = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/msf_time_code_encoder.sv
// MSF 60-second time-code frame generator.
//   clk_i, rst_ni        : clock, async active-low reset
//   tick_i               : 1 Hz strobe, each one starts a new second
//   *_h_i / *_l_i, dow_i : BCD time/date of the NEXT minute marker
//   bst_warn_i, bst_i    : summer-time flags
//   bits_valid_o         : one-cycle strobe, one clk after tick_i
//   bits_is_second_00_o  : current second is the minute marker
//   bits_data_o          : {A, B} of the current second
//   second_o             : current second, 0..59
//   carrier_off_o        : carrier keying, 1 = off
//   frame_start_o        : strobe when the inputs are captured
module msf_time_code_encoder
  import msf_pkg::*;
#(
  parameter int SLOT_CYCLES = 3277
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic [3:0] year_h_i,
  input  logic [3:0] year_l_i,
  input  logic       month_h_i,
  input  logic [3:0] month_l_i,
  input  logic [1:0] day_h_i,
  input  logic [3:0] day_l_i,
  input  logic [2:0] dow_i,
  input  logic [1:0] hour_h_i,
  input  logic [3:0] hour_l_i,
  input  logic [2:0] minute_h_i,
  input  logic [3:0] minute_l_i,
  input  logic       bst_warn_i,
  input  logic       bst_i,
  output logic       bits_valid_o,
  output logic       bits_is_second_00_o,
  output logic [1:0] bits_data_o,
  output logic [5:0] second_o,
  output logic       carrier_off_o,
  output logic       frame_start_o
);

  state_t    state;
  logic [5:0] sec_q, sec_nxt;
  logic       wrap;
  snapshot_t  snap, snap_in;
  logic [1:0] bits_nxt;

  assign snap_in  = {year_h_i, year_l_i, month_h_i, month_l_i, day_h_i, day_l_i, dow_i,
                     hour_h_i, hour_l_i, minute_h_i, minute_l_i, bst_warn_i, bst_i};
  // The first tick out of IDLE always lands on second 0.
  assign sec_nxt  = (state == ST_IDLE || sec_q == SEC_LAST) ? 6'd0 : sec_q + 6'd1;
  assign wrap     = (sec_nxt == 6'd0);
  // Second 0 carries no snapshot data, so the held snapshot is safe to use
  // on the wrap tick itself.
  assign bits_nxt = frame_bits(sec_nxt, snap);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state               <= ST_IDLE;
      sec_q               <= SEC_LAST;
      snap                <= '0;
      bits_valid_o        <= 1'b0;
      bits_is_second_00_o <= 1'b0;
      bits_data_o         <= '0;
      second_o            <= '0;
      frame_start_o       <= 1'b0;
    end else begin
      bits_valid_o  <= tick_i;
      frame_start_o <= tick_i & wrap;
      if (tick_i) begin
        state               <= ST_RUN;
        sec_q               <= sec_nxt;
        second_o            <= sec_nxt;
        bits_is_second_00_o <= wrap;
        bits_data_o         <= bits_nxt;
        if (wrap) snap <= snap_in;
      end
    end
  end

  msf_carrier_modulator #(.SLOT_CYCLES(SLOT_CYCLES)) u_mod (
    .clk          (clk_i),
    .rst_n        (rst_ni),
    .tick         (tick_i),
    .a            (bits_nxt[1]),
    .b            (bits_nxt[0]),
    .is_second_00 (wrap),
    .carrier_off  (carrier_off_o)
  );

endmodule

// File: tb/tb_msf_time_code_encoder.sv
// Self-checking bench for msf_time_code_encoder with a frame-level model.
module tb_msf_time_code_encoder;

  localparam int SC = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni, tick_i;
  logic [3:0] year_h_i, year_l_i, month_l_i, day_l_i, hour_l_i, minute_l_i;
  logic       month_h_i, bst_warn_i, bst_i;
  logic [1:0] day_h_i, hour_h_i;
  logic [2:0] dow_i, minute_h_i;
  logic       bits_valid_o, bits_is_second_00_o, carrier_off_o, frame_start_o;
  logic [1:0] bits_data_o;
  logic [5:0] second_o;

  msf_time_code_encoder #(.SLOT_CYCLES(SC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .tick_i(tick_i),
    .year_h_i(year_h_i), .year_l_i(year_l_i), .month_h_i(month_h_i), .month_l_i(month_l_i),
    .day_h_i(day_h_i), .day_l_i(day_l_i), .dow_i(dow_i), .hour_h_i(hour_h_i),
    .hour_l_i(hour_l_i), .minute_h_i(minute_h_i), .minute_l_i(minute_l_i),
    .bst_warn_i(bst_warn_i), .bst_i(bst_i),
    .bits_valid_o(bits_valid_o), .bits_is_second_00_o(bits_is_second_00_o),
    .bits_data_o(bits_data_o), .second_o(second_o), .carrier_off_o(carrier_off_o),
    .frame_start_o(frame_start_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model: second index, captured frame, expected A/B per second.
  int         m_sec;
  bit         a_exp[60], b_exp[60], obs_a[60], obs_b[60];
  logic [7:0] s_year;
  logic [4:0] s_month;
  logic [5:0] s_day, s_hour;
  logic [2:0] s_dow;
  logic [6:0] s_min;
  bit         s_warn, s_bst;
  int         w8[8] = '{80, 40, 20, 10, 8, 4, 2, 1};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void put(int first, int width, logic [7:0] val);
    for (int i = 0; i < width; i++) a_exp[first + i] = val[width - 1 - i];
  endfunction

  function automatic bit odd_par(int lo, int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(a_exp[i]);
    return (n % 2) == 0;
  endfunction

  function automatic void build_frame();
    for (int i = 0; i < 60; i++) begin a_exp[i] = 0; b_exp[i] = 0; end
    a_exp[0] = 1; b_exp[0] = 1;
    put(17, 8, s_year);
    put(25, 5, 8'(s_month));
    put(30, 6, 8'(s_day));
    put(36, 3, 8'(s_dow));
    put(39, 6, 8'(s_hour));
    put(45, 7, 8'(s_min));
    for (int i = 53; i <= 58; i++) a_exp[i] = 1;
    b_exp[53] = odd_par(17, 24);
    b_exp[54] = odd_par(25, 35);
    b_exp[55] = odd_par(36, 38);
    b_exp[56] = odd_par(39, 51);
    b_exp[57] = s_warn;
    b_exp[58] = s_bst;
  endfunction

  task automatic model_tick();
    m_sec = (m_sec + 1) % 60;
    if (m_sec == 0) begin
      s_year = {year_h_i, year_l_i};  s_month = {month_h_i, month_l_i};
      s_day  = {day_h_i, day_l_i};    s_dow   = dow_i;
      s_hour = {hour_h_i, hour_l_i};  s_min   = {minute_h_i, minute_l_i};
      s_warn = bst_warn_i;            s_bst   = bst_i;
      build_frame();
    end
  endtask

  task automatic rand_inputs();
    year_h_i = 4'($urandom);  year_l_i = 4'($urandom);
    month_h_i = 1'($urandom); month_l_i = 4'($urandom);
    day_h_i = 2'($urandom);   day_l_i = 4'($urandom);
    dow_i = 3'($urandom);
    hour_h_i = 2'($urandom);  hour_l_i = 4'($urandom);
    minute_h_i = 3'($urandom); minute_l_i = 4'($urandom);
    bst_warn_i = 1'($urandom); bst_i = 1'($urandom);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, bits_valid_o, 0);
    check({tag, "_is00"}, bits_is_second_00_o, 0);
    check({tag, "_data"}, bits_data_o, 0);
    check({tag, "_second"}, second_o, 0);
    check({tag, "_carrier"}, carrier_off_o, 0);
    check({tag, "_frame_start"}, frame_start_o, 0);
  endtask

  // One tick, then check the second's outputs; 'full' also watches the
  // whole keying window, otherwise the next tick comes early and aborts it.
  task automatic tick_check(input bit full);
    logic [47:0] obs, exp;
    int slot;
    @(negedge clk_i); tick_i = 1'b1; model_tick();
    @(negedge clk_i); tick_i = 1'b0;
    check($sformatf("valid@%0d", m_sec), bits_valid_o, 1);
    check($sformatf("second@%0d", m_sec), second_o, m_sec);
    check($sformatf("is00@%0d", m_sec), bits_is_second_00_o, m_sec == 0);
    check($sformatf("data@%0d", m_sec), bits_data_o, {a_exp[m_sec], b_exp[m_sec]});
    check($sformatf("frame_start@%0d", m_sec), frame_start_o, m_sec == 0);
    obs_a[m_sec] = bits_data_o[1];
    obs_b[m_sec] = bits_data_o[0];
    obs = '0;
    obs[0] = carrier_off_o;
    @(negedge clk_i);
    check($sformatf("valid_pulse@%0d", m_sec), bits_valid_o, 0);
    obs[1] = carrier_off_o;
    if (full) begin
      for (int j = 2; j < 48; j++) begin
        @(negedge clk_i);
        obs[j] = carrier_off_o;
      end
      for (int j = 0; j < 48; j++) begin
        slot = j / SC;
        if (j >= 10 * SC)  exp[j] = 1'b0;
        else if (m_sec == 0) exp[j] = (slot < 5);
        else exp[j] = (slot == 0) || (slot == 1 && a_exp[m_sec]) || (slot == 2 && b_exp[m_sec]);
      end
      check($sformatf("carrier@%0d", m_sec), obs, exp);
    end
  endtask

  function automatic int decode(int first, int width);
    int v = 0;
    for (int i = 0; i < width; i++) if (obs_a[first + i]) v += w8[8 - width + i];
    return v;
  endfunction

  initial begin
    logic [7:0] pat8;
    logic [5:0] pat6;
    rst_ni = 1'b0; tick_i = 1'b0;
    year_h_i = 0; year_l_i = 0; month_h_i = 0; month_l_i = 0; day_h_i = 0; day_l_i = 0;
    dow_i = 0; hour_h_i = 0; hour_l_i = 0; minute_h_i = 0; minute_l_i = 0;
    bst_warn_i = 0; bst_i = 0;
    m_sec = 59;
    repeat (3) @(negedge clk_i);
    check_zero("in_reset");
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_zero("after_reset");

    // Directed frame: 23-06-15, Thursday, 14:36, summer time.
    year_h_i = 2; year_l_i = 3; month_h_i = 0; month_l_i = 6; day_h_i = 1; day_l_i = 5;
    dow_i = 4; hour_h_i = 1; hour_l_i = 4; minute_h_i = 3; minute_l_i = 6;
    bst_warn_i = 0; bst_i = 1;
    for (int s = 0; s < 60; s++) tick_check(1'b1);

    for (int i = 0; i < 8; i++) pat8[7 - i] = obs_a[17 + i];
    check("year_bits", pat8, 8'b00100011);
    for (int i = 0; i < 8; i++) pat8[7 - i] = obs_a[52 + i];
    check("tail_a_bits", pat8, 8'b01111110);
    for (int i = 0; i < 6; i++) pat6[5 - i] = obs_b[53 + i];
    check("tail_b_bits", pat6, 6'b000101);
    check("dec_year", decode(17, 8), 23);
    check("dec_month", decode(25, 5), 6);
    check("dec_day", decode(30, 6), 15);
    check("dec_dow", decode(36, 3), 4);
    check("dec_hour", decode(39, 6), 14);
    check("dec_minute", decode(45, 7), 36);

    // Random frame; inputs change mid-frame and must not leak in.
    rand_inputs();
    for (int s = 0; s < 60; s++) begin
      if (s == 30) rand_inputs();
      tick_check((s % 7) != 3);
    end

    // Tick held high for three cycles: three advances.
    @(negedge clk_i); tick_i = 1'b1; model_tick();
    @(negedge clk_i); model_tick();
    @(negedge clk_i); model_tick();
    @(negedge clk_i); tick_i = 1'b0;
    check("burst_second", second_o, m_sec);
    check("burst_valid", bits_valid_o, 1);
    check("burst_data", bits_data_o, {a_exp[m_sec], b_exp[m_sec]});
    check("burst_frame_start", frame_start_o, 0);

    // Reset in the middle of second 30, then a fresh frame.
    while (m_sec != 30) tick_check(1'b0);
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_zero("mid_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    m_sec = 59;
    rand_inputs();
    for (int s = 0; s < 60; s++) tick_check((s % 5) != 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msf_time_code_encoder.md
Name: msf_time_code_encoder

Overview:
- Generates an MSF 60-second time-code frame from BCD time/date fields.
- Produces the same per-second bit stream the receive-side time/date decoder consumes: bits_valid / bits_is_second_00 / bits_data.
- Also produces a carrier on/off keying waveform, for loop-back testing of the receive chain and for driving a test transmitter.
- Sits after a 1 Hz tick source; its bit outputs connect directly to the decoder inputs.

Parameters:
- SLOT_CYCLES, 3277: clk cycles per 100 ms modulation slot (≈100 ms at 32.768 kHz). Minimum 2.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous, active-low reset
- tick_i  in  1  one-cycle 1 Hz strobe; each strobe starts a new second
- year_h_i  in  4  BCD year tens
- year_l_i  in  4  BCD year units
- month_h_i  in  1  BCD month tens
- month_l_i  in  4  BCD month units
- day_h_i  in  2  BCD day tens
- day_l_i  in  4  BCD day units
- dow_i  in  3  day of week, 0 = Sunday
- hour_h_i  in  2  BCD hour tens
- hour_l_i  in  4  BCD hour units
- minute_h_i  in  3  BCD minute tens
- minute_l_i  in  4  BCD minute units
- bst_warn_i  in  1  summer-time change imminent
- bst_i  in  1  summer time in force
- bits_valid_o  out  1  one-cycle strobe per second
- bits_is_second_00_o  out  1  qualifies bits_valid_o: minute marker
- bits_data_o  out  2  [1] = A bit, [0] = B bit of the current second
- second_o  out  6  current second index, 0..59
- carrier_off_o  out  1  1 = carrier off
- frame_start_o  out  1  one-cycle strobe when inputs are captured

Behaviour:
- Reset values: all outputs 0, carrier_off_o 0 (carrier on), FSM in IDLE, second counter 59, snapshot cleared.
- FSM states: IDLE → RUN on the first tick_i. RUN persists until reset. No other transitions.
- Every tick_i:
  - Second counter advances; 59 wraps to 0. The first tick after reset yields second 0.
  - On wrap to 0, all *_i fields are registered into the snapshot and frame_start_o pulses in the same cycle.
  - Inputs must describe the time at the NEXT minute marker, per MSF convention.
  - Inputs are not range-checked; BCD values are transmitted as given.
- Latency: bits_valid_o, bits_is_second_00_o, bits_data_o and second_o update one clk after tick_i. bits_valid_o is high for exactly that one cycle. bits_data_o holds until the next tick.
- A bits by second:
  - 00: 1
  - 01-16: 0 (DUT1 not supported)
  - 17-24: year, MSB first (80, 40, 20, 10, 8, 4, 2, 1)
  - 25-29: month (10, 8, 4, 2, 1)
  - 30-35: day (20, 10, 8, 4, 2, 1)
  - 36-38: dow (4, 2, 1)
  - 39-44: hour (20, 10, 8, 4, 2, 1)
  - 45-51: minute (40, 20, 10, 8, 4, 2, 1)
  - 52: 0
  - 53-58: 1
  - 59: 0
- B bits by second:
  - 00: 1
  - 01-52: 0
  - 53-56: odd parity over 17-24 / 25-35 / 36-38 / 39-51 respectively (parity bit = XNOR-reduce of the covered A bits)
  - 57: bst_warn
  - 58: bst
  - 59: 0
- Carrier keying: slot counter 0..9 with SLOT_CYCLES clk per slot, restarted by tick_i at the same cycle bits_valid_o rises.
  - Second 00: off for slots 0-4.
  - Other seconds: slot 0 off, slot 1 off iff A = 1, slot 2 off iff B = 1.
  - All other slots: on.
  - After slot 9 completes without a new tick, carrier stays on.
  - An early tick aborts the current second and restarts at slot 0.
- tick_i asserted continuously: one advance per cycle; no error flagged.
- Reset mid-frame: immediate return to reset values. The next tick starts second 0.

Decomposition:
- Package msf_pkg:
  - second-index constants (SEC_YEAR_FIRST = 17, SEC_MONTH_FIRST = 25, SEC_DAY_FIRST = 30, SEC_DOW_FIRST = 36, SEC_HOUR_FIRST = 39, SEC_MIN_FIRST = 45, SEC_PAR_YEAR = 53 … SEC_BST = 58)
  - SLOTS_PER_SECOND = 10
  - minute-marker slot count = 5
  - FSM state enum
- Sub-module msf_carrier_modulator: inputs tick, A, B, is_second_00; output carrier_off; holds the slot and cycle counters.

Test Plan:
- Reset, then 1 tick → bits_valid_o pulse 1 clk later, bits_is_second_00_o = 1, bits_data_o = 2'b11, second_o = 0, frame_start_o pulsed.
- Inputs 23-06-15, dow 4, 14:36, bst 1, bst_warn 0; run 60 ticks. Expected A bits:
  - 17-24: 00100011
  - 25-29: 00110
  - 30-35: 010101
  - 36-38: 100
  - 39-44: 010100
  - 45-51: 0110110
- Same frame, expected B bits: B53 = 0, B54 = 0, B55 = 0, B56 = 1, B57 = 0, B58 = 1; 52-59 A pattern 01111110.
- Loop-back: encoder outputs into time_date_decoder across 2 frames → decoder valid_o = 1 with hour 14, minute 36, day 15, month 06, year 23, dow 4.
- SLOT_CYCLES = 4. Second 00: carrier_off_o high 20 clk. Second with A = 1, B = 0: high 8 clk, then low.
- Reset asserted at second 30 mid-slot → all outputs 0 immediately. Next tick → second_o = 0 and a new snapshot.
